// File: rtl/alu_ctl_if.sv
// ALU control handshake bundle between the ID stage (master) and the
// ID/EX ALU-control register stage (slave).
interface alu_ctl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [1:0]       id_aluop;
    logic [5:0]       id_funct;
    logic [5:0]       id_opcode;
    logic             ex_stall;
    logic             ex_flush;
    logic             clr_status;
    logic             ex_valid;
    logic [3:0]       ex_aluctl;
    logic             ex_illegal;
    logic             illegal_seen;
    logic [CNT_W-1:0] issue_cnt;

    modport master (
        output id_valid, id_aluop, id_funct, id_opcode,
        output ex_stall, ex_flush, clr_status,
        input  ex_valid, ex_aluctl, ex_illegal, illegal_seen, issue_cnt
    );

    modport slave (
        input  id_valid, id_aluop, id_funct, id_opcode,
        input  ex_stall, ex_flush, clr_status,
        output ex_valid, ex_aluctl, ex_illegal, illegal_seen, issue_cnt
    );
endinterface

// File: rtl/alu_ctl_stage.sv
// ALU control decode plus ID/EX register: turns ALUOp + funct/opcode into
// the 4-bit ALUctl code, registers it with flush/stall handling, and keeps
// a sticky illegal-op flag and an issued-op counter for debug.
module alu_ctl_stage #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_ctl_if.slave bus
);
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_ILL = 4'b1111;

    logic [3:0]       dec_aluctl;
    logic             dec_illegal;
    logic             load;

    logic             ex_valid_q, ex_valid_d;
    logic [3:0]       ex_aluctl_q, ex_aluctl_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic             illegal_seen_q, illegal_seen_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    // Pure combinational decode of the current ID-stage fields.
    always_comb begin
        dec_aluctl  = CTL_ILL;
        dec_illegal = 1'b0;
        case (bus.id_aluop)
            2'b00: dec_aluctl = CTL_ADD;
            2'b01: dec_aluctl = CTL_SUB;
            2'b10: begin
                case (bus.id_funct)
                    6'b100000, 6'b100001: dec_aluctl = CTL_ADD;
                    6'b100010, 6'b100011: dec_aluctl = CTL_SUB;
                    6'b100100:            dec_aluctl = CTL_AND;
                    6'b100101:            dec_aluctl = CTL_OR;
                    6'b101010:            dec_aluctl = CTL_SLT;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (bus.id_opcode)
                    6'b001000, 6'b001001: dec_aluctl = CTL_ADD;
                    6'b001100:            dec_aluctl = CTL_AND;
                    6'b001101:            dec_aluctl = CTL_OR;
                    6'b001010:            dec_aluctl = CTL_SLT;
                    default:              dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Next-state for the ID/EX register (flush > stall > load) and debug status.
    always_comb begin
        load           = !bus.ex_flush && !bus.ex_stall;
        ex_valid_d     = ex_valid_q;
        ex_aluctl_d    = ex_aluctl_q;
        ex_illegal_d   = ex_illegal_q;
        illegal_seen_d = illegal_seen_q;
        issue_cnt_d    = issue_cnt_q;

        if (bus.ex_flush) begin
            ex_valid_d   = 1'b0;
            ex_aluctl_d  = CTL_AND;
            ex_illegal_d = 1'b0;
        end else if (!bus.ex_stall) begin
            ex_valid_d   = bus.id_valid;
            ex_aluctl_d  = bus.id_valid ? dec_aluctl : CTL_AND;
            ex_illegal_d = bus.id_valid & dec_illegal;
        end

        // Clear wins over a same-cycle increment or illegal set.
        if (bus.clr_status) begin
            illegal_seen_d = 1'b0;
            issue_cnt_d    = '0;
        end else if (load && bus.id_valid) begin
            illegal_seen_d = illegal_seen_q | dec_illegal;
            issue_cnt_d    = issue_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_aluctl_q    <= CTL_AND;
            ex_illegal_q   <= 1'b0;
            illegal_seen_q <= 1'b0;
            issue_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_aluctl_q    <= ex_aluctl_d;
            ex_illegal_q   <= ex_illegal_d;
            illegal_seen_q <= illegal_seen_d;
            issue_cnt_q    <= issue_cnt_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_aluctl    = ex_aluctl_q;
    assign bus.ex_illegal   = ex_illegal_q;
    assign bus.illegal_seen = illegal_seen_q;
    assign bus.issue_cnt    = issue_cnt_q;
endmodule

// File: tb/tb_alu_ctl_stage.sv
// Self-checking bench for alu_ctl_stage: directed vector table, random
// traffic against a lookup-table reference model, async-reset and
// counter-wrap sequences.
module tb_alu_ctl_stage;
    logic clk;
    logic rst_n;

    alu_ctl_if #(.CNT_W(16)) bus ();
    alu_ctl_if #(.CNT_W(4))  bus4 ();

    alu_ctl_stage #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_ctl_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: ALU function tables keyed by field value.
    logic [3:0] funct_map [logic [5:0]];
    logic [3:0] opc_map   [logic [5:0]];
    logic       m_valid;
    logic [3:0] m_ctl;
    logic       m_ill;
    logic       m_seen;
    int         m_cnt;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] o;
        logic       st, fl, cl;
        logic       ev;
        logic [3:0] ec;
        logic       ei, es;
        int         ecnt;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [5:0] f, logic [5:0] o,
                                logic st, logic fl, logic cl,
                                logic ev, logic [3:0] ec, logic ei, logic es, int ecnt);
        vec_t r;
        r.v = v; r.op = op; r.f = f; r.o = o; r.st = st; r.fl = fl; r.cl = cl;
        r.ev = ev; r.ec = ec; r.ei = ei; r.es = es; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f, input logic [5:0] o,
                              output logic [3:0] c, output logic ill);
        ill = 1'b0;
        c   = 4'b1111;
        if (op == 2'd0) c = 4'b0010;
        else if (op == 2'd1) c = 4'b0110;
        else if (op == 2'd2) begin
            if (funct_map.exists(f)) c = funct_map[f]; else ill = 1'b1;
        end else begin
            if (opc_map.exists(o)) c = opc_map[o]; else ill = 1'b1;
        end
    endtask

    task automatic model_step(input logic v, input logic [1:0] op, input logic [5:0] f,
                              input logic [5:0] o, input logic st, input logic fl, input logic cl);
        logic [3:0] c;
        logic       ill;
        ref_decode(op, f, o, c, ill);
        if (cl) begin
            m_cnt  = 0;
            m_seen = 1'b0;
        end else if (!fl && !st && v) begin
            m_cnt  = (m_cnt + 1) % 65536;
            m_seen = m_seen | ill;
        end
        if (fl) begin
            m_valid = 1'b0; m_ctl = 4'b0000; m_ill = 1'b0;
        end else if (!st) begin
            m_valid = v;
            m_ctl   = v ? c : 4'b0000;
            m_ill   = v & ill;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctl = 4'b0000; m_ill = 1'b0; m_seen = 1'b0; m_cnt = 0;
    endtask

    // Drive one transaction, advance past the next rising edge, step the model.
    task automatic apply(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [5:0] o, input logic st, input logic fl, input logic cl);
        bus.id_valid   = v;
        bus.id_aluop   = op;
        bus.id_funct   = f;
        bus.id_opcode  = o;
        bus.ex_stall   = st;
        bus.ex_flush   = fl;
        bus.clr_status = cl;
        model_step(v, op, f, o, st, fl, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ex_valid"},     32'(bus.ex_valid),     32'(m_valid));
        check({tag, ".ex_aluctl"},    32'(bus.ex_aluctl),    32'(m_ctl));
        check({tag, ".ex_illegal"},   32'(bus.ex_illegal),   32'(m_ill));
        check({tag, ".illegal_seen"}, 32'(bus.illegal_seen), 32'(m_seen));
        check({tag, ".issue_cnt"},    32'(bus.issue_cnt),    32'(m_cnt));
    endtask

    initial begin
        funct_map[6'b100000] = 4'b0010; funct_map[6'b100001] = 4'b0010;
        funct_map[6'b100010] = 4'b0110; funct_map[6'b100011] = 4'b0110;
        funct_map[6'b100100] = 4'b0000; funct_map[6'b100101] = 4'b0001;
        funct_map[6'b101010] = 4'b0111;
        opc_map[6'b001000] = 4'b0010; opc_map[6'b001001] = 4'b0010;
        opc_map[6'b001100] = 4'b0000; opc_map[6'b001101] = 4'b0001;
        opc_map[6'b001010] = 4'b0111;

        //               v  op  funct      opcode     st fl cl   ev ctl   ei es cnt
        tbl[0]  = mk(1, 2, 6'b101010, 6'b000000, 0, 0, 0, 1, 4'h7, 0, 0, 1);
        tbl[1]  = mk(1, 3, 6'b000000, 6'b001101, 0, 0, 0, 1, 4'h1, 0, 0, 2);
        tbl[2]  = mk(1, 0, 6'b000000, 6'b111111, 0, 0, 0, 1, 4'h2, 0, 0, 3);
        tbl[3]  = mk(1, 1, 6'b000000, 6'b111111, 0, 0, 0, 1, 4'h6, 0, 0, 4);
        tbl[4]  = mk(1, 2, 6'b000000, 6'b000000, 0, 0, 0, 1, 4'hf, 1, 1, 5);
        tbl[5]  = mk(1, 0, 6'b000000, 6'b000000, 0, 0, 0, 1, 4'h2, 0, 1, 6);
        tbl[6]  = mk(0, 2, 6'b000000, 6'b000000, 0, 0, 0, 0, 4'h0, 0, 1, 6);
        tbl[7]  = mk(1, 0, 6'b000000, 6'b000000, 0, 0, 1, 1, 4'h2, 0, 0, 0);
        tbl[8]  = mk(1, 0, 6'b000000, 6'b000000, 0, 0, 0, 1, 4'h2, 0, 0, 1);
        tbl[9]  = mk(1, 1, 6'b000000, 6'b000000, 1, 0, 0, 1, 4'h2, 0, 0, 1);
        tbl[10] = mk(1, 1, 6'b000000, 6'b000000, 1, 0, 0, 1, 4'h2, 0, 0, 1);
        tbl[11] = mk(1, 1, 6'b000000, 6'b000000, 1, 0, 0, 1, 4'h2, 0, 0, 1);
        tbl[12] = mk(1, 1, 6'b000000, 6'b000000, 0, 0, 0, 1, 4'h6, 0, 0, 2);
        tbl[13] = mk(1, 2, 6'b100100, 6'b000000, 1, 1, 0, 0, 4'h0, 0, 0, 2);
        tbl[14] = mk(1, 3, 6'b000000, 6'b001001, 0, 0, 0, 1, 4'h2, 0, 0, 3);
        tbl[15] = mk(1, 3, 6'b000000, 6'b111111, 0, 0, 0, 1, 4'hf, 1, 1, 4);
        tbl[16] = mk(1, 2, 6'b000001, 6'b000000, 1, 0, 0, 1, 4'hf, 1, 1, 4);
        tbl[17] = mk(0, 0, 6'b000000, 6'b000000, 0, 1, 0, 0, 4'h0, 0, 1, 4);
        tbl[18] = mk(1, 0, 6'b000000, 6'b000000, 1, 0, 1, 0, 4'h0, 0, 0, 0);
        tbl[19] = mk(1, 2, 6'b100011, 6'b000000, 0, 0, 0, 1, 4'h6, 0, 0, 1);
        tbl[20] = mk(1, 2, 6'b100001, 6'b000000, 0, 0, 0, 1, 4'h2, 0, 0, 2);
        tbl[21] = mk(1, 2, 6'b100101, 6'b000000, 0, 0, 0, 1, 4'h1, 0, 0, 3);
        tbl[22] = mk(1, 2, 6'b100100, 6'b000000, 0, 0, 0, 1, 4'h0, 0, 0, 4);
        tbl[23] = mk(1, 3, 6'b000000, 6'b001100, 0, 0, 0, 1, 4'h0, 0, 0, 5);
        tbl[24] = mk(1, 3, 6'b000000, 6'b001010, 0, 0, 0, 1, 4'h7, 0, 0, 6);
        tbl[25] = mk(1, 3, 6'b000000, 6'b001000, 0, 0, 0, 1, 4'h2, 0, 0, 7);
        tbl[26] = mk(1, 2, 6'b111111, 6'b000000, 0, 0, 1, 1, 4'hf, 1, 0, 0);
        tbl[27] = mk(1, 2, 6'b100000, 6'b000000, 0, 0, 0, 1, 4'h2, 0, 0, 1);
        tbl[28] = mk(1, 2, 6'b100010, 6'b000000, 0, 0, 0, 1, 4'h6, 0, 0, 2);

        // Idle inputs, reset asserted.
        rst_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_aluop = 2'd0; bus.id_funct = 6'd0; bus.id_opcode = 6'd0;
        bus.ex_stall = 1'b0; bus.ex_flush = 1'b0; bus.clr_status = 1'b0;
        bus4.id_valid = 1'b0; bus4.id_aluop = 2'd0; bus4.id_funct = 6'd0; bus4.id_opcode = 6'd0;
        bus4.ex_stall = 1'b0; bus4.ex_flush = 1'b0; bus4.clr_status = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        $display("reset: ex_valid=%0b ex_aluctl=%b cnt=%0d", bus.ex_valid, bus.ex_aluctl, bus.issue_cnt);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].v, tbl[i].op, tbl[i].f, tbl[i].o, tbl[i].st, tbl[i].fl, tbl[i].cl);
            $display("vec %0d: v=%0b op=%0d f=%b o=%b st=%0b fl=%0b cl=%0b -> valid=%0b ctl=%b ill=%0b seen=%0b cnt=%0d",
                     i, tbl[i].v, tbl[i].op, tbl[i].f, tbl[i].o, tbl[i].st, tbl[i].fl, tbl[i].cl,
                     bus.ex_valid, bus.ex_aluctl, bus.ex_illegal, bus.illegal_seen, bus.issue_cnt);
            check($sformatf("vec%0d.ex_valid", i),     32'(bus.ex_valid),     32'(tbl[i].ev));
            check($sformatf("vec%0d.ex_aluctl", i),    32'(bus.ex_aluctl),    32'(tbl[i].ec));
            check($sformatf("vec%0d.ex_illegal", i),   32'(bus.ex_illegal),   32'(tbl[i].ei));
            check($sformatf("vec%0d.illegal_seen", i), 32'(bus.illegal_seen), 32'(tbl[i].es));
            check($sformatf("vec%0d.issue_cnt", i),    32'(bus.issue_cnt),    32'(tbl[i].ecnt));
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic       v, st, fl, cl;
            logic [1:0] op;
            logic [5:0] f, o;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 19) == 0);
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 1) == 0) ? 6'($urandom) : (6'b100000 | 6'($urandom_range(0, 10)));
            o  = ($urandom_range(0, 1) == 0) ? 6'($urandom) : (6'b001000 | 6'($urandom_range(0, 5)));
            apply(v, op, f, o, st, fl, cl);
            $display("rnd %0d: v=%0b op=%0d f=%b o=%b st=%0b fl=%0b cl=%0b -> ctl=%b cnt=%0d",
                     i, v, op, f, o, st, fl, cl, bus.ex_aluctl, bus.issue_cnt);
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset while stalled: outputs clear without a clock edge.
        apply(1'b1, 2'd2, 6'b000111, 6'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd1, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        check_model("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("async rst: valid=%0b ctl=%b ill=%0b seen=%0b cnt=%0d",
                 bus.ex_valid, bus.ex_aluctl, bus.ex_illegal, bus.illegal_seen, bus.issue_cnt);
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        rst_n = 1'b1;
        apply(1'b1, 2'd1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        $display("post rst load: valid=%0b ctl=%b cnt=%0d", bus.ex_valid, bus.ex_aluctl, bus.issue_cnt);
        check_model("post_rst");

        // Narrow counter wraps from all-ones back to zero.
        bus4.clr_status = 1'b1;
        @(posedge clk);
        #1;
        check("wrap.clear", 32'(bus4.issue_cnt), 32'd0);
        bus4.clr_status = 1'b0;
        bus4.id_valid   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            $display("wrap op %0d: issue_cnt=%0d", k, bus4.issue_cnt);
            check($sformatf("wrap%0d.issue_cnt", k), 32'(bus4.issue_cnt), 32'(k % 16));
        end
        bus4.id_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
